// File: rtl/sync_decoder_pkg.sv
// Shared definitions for the sync decoder and its timing-generator peer.
// Holds the decoder state encoding, the raster counter widths and the
// default raster timing so that both ends of the sync link agree.
package sync_decoder_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam int COL_W = 10;
  localparam int ROW_W = 9;

  localparam int DEF_LINE_CLKS    = 459;
  localparam int DEF_LINE_TOL     = 2;
  localparam int DEF_HSYNC_CLKS   = 29;
  localparam int DEF_FRAME_LINES0 = 259;
  localparam int DEF_FRAME_LINES1 = 312;
  localparam int DEF_LOCK_FRAMES  = 2;

  // Inclusive range test on a measured line length.
  function automatic logic in_window(input logic [COL_W:0] val,
                                     input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

endpackage

// File: rtl/sync_decoder_edge.sv
// Registers one active-low sync input and produces registered fall/rise
// pulses for it.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   level        : raw sync input (already in the clk domain)
//   q            : level delayed by one clock (resets high = inactive)
//   fall         : one-clock pulse, registered, after a 1->0 transition
//   rise         : one-clock pulse, registered, after a 0->1 transition
module sync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic q,
  output logic fall,
  output logic rise
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= 1'b1;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      q    <= level;
      fall <= q & ~level;
      rise <= ~q & level;
    end
  end

endmodule

// File: rtl/sync_decoder.sv
// Sync decoder: recovers column/row raster position and frame format from
// an active-low hsn/fsn pair, validates line/frame timing and reports lock.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   hsn, fsn     : active-low horizontal / frame sync inputs
//   col, row     : recovered raster position
//   format       : 0 = FRAME_LINES0 frame, 1 = FRAME_LINES1 frame
//   locked       : timing validated
//   line_start   : pulse at each recovered line start
//   frame_start  : pulse at each recovered frame start
//   sync_err     : pulse on any line or frame check failure
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_SEARCH  | no frame reference; wait for the first frame start
// ST_MEASURE | counting consecutive good frames of a consistent format
// ST_LOCKED  | timing validated; format tracked, errors reported
module sync_decoder
  import sync_decoder_pkg::*;
#(
  parameter int LINE_CLKS    = DEF_LINE_CLKS,
  parameter int LINE_TOL     = DEF_LINE_TOL,
  parameter int HSYNC_CLKS   = DEF_HSYNC_CLKS,
  parameter int FRAME_LINES0 = DEF_FRAME_LINES0,
  parameter int FRAME_LINES1 = DEF_FRAME_LINES1,
  parameter int LOCK_FRAMES  = DEF_LOCK_FRAMES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hsn,
  input  logic             fsn,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             format,
  output logic             locked,
  output logic             line_start,
  output logic             frame_start,
  output logic             sync_err
);

  localparam int CNT_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_FRAMES);
  localparam logic [COL_W-1:0] COL_MAX  = '1;
  localparam logic [ROW_W-1:0] ROW_MAX  = '1;
  localparam logic [COL_W-1:0] HS_LEN   = COL_W'(HSYNC_CLKS);
  localparam logic [ROW_W:0]   F0_LEN   = (ROW_W+1)'(FRAME_LINES0);
  localparam logic [ROW_W:0]   F1_LEN   = (ROW_W+1)'(FRAME_LINES1);

  logic hsn_q, hsn_fall, hsn_rise;
  logic fsn_q, fsn_fall, fsn_rise;
  logic unused_fsn_edges;

  sync_edge_detect u_hsn (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (hsn),
    .q       (hsn_q),
    .fall    (hsn_fall),
    .rise    (hsn_rise)
  );

  sync_edge_detect u_fsn (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (fsn),
    .q       (fsn_q),
    .fall    (fsn_fall),
    .rise    (fsn_rise)
  );

  // Only the registered fsn level is used; frame start is qualified by line starts.
  assign unused_fsn_edges = fsn_fall | fsn_rise;

  state_t           state;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             last_fmt;
  logic             fsn_prev_ls;
  logic [COL_W-1:0] hs_low;

  logic             line_evt, frame_evt, timeout;
  logic [COL_W:0]   line_len;
  logic [ROW_W:0]   frame_len;
  logic             len_err, hs_err, line_err;
  logic             good0, good1, frame_good, frame_err, meas_fmt;

  assign line_evt  = hsn_fall;
  // fsn_q holds fsn as sampled on the same edge that first saw hsn low.
  assign frame_evt = line_evt & ~fsn_q & fsn_prev_ls;
  assign timeout   = ~line_evt & (col == COL_MAX - 1'b1);

  assign line_len  = {1'b0, col} + 1'b1;
  assign len_err   = line_evt & ~in_window(line_len, LINE_CLKS - LINE_TOL,
                                           LINE_CLKS + LINE_TOL);
  assign hs_err    = hsn_rise & (hs_low != HS_LEN);
  assign line_err  = len_err | hs_err;

  assign frame_len  = {1'b0, row} + 1'b1;
  assign good0      = (frame_len == F0_LEN);
  assign good1      = (frame_len == F1_LEN);
  assign frame_good = frame_evt & (good0 | good1);
  assign frame_err  = frame_evt & ~(good0 | good1);
  assign meas_fmt   = good1;

  // A format change restarts the run at one good frame (this one).
  assign cnt_next = (meas_fmt != last_fmt) ? CNT_W'(1) : good_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col         <= '0;
      row         <= '0;
      hs_low      <= '0;
      fsn_prev_ls <= 1'b1;
    end else begin
      if (line_evt)
        col <= '0;
      else if (col != COL_MAX)
        col <= col + 1'b1;

      if (timeout || frame_evt)
        row <= '0;
      else if (line_evt && (row != ROW_MAX))
        row <= row + 1'b1;

      if (line_evt)
        fsn_prev_ls <= fsn_q;

      // The registered fall arrives one clock into the low run, so start at 1.
      if (hsn_fall)
        hs_low <= COL_W'(1);
      else if (!hsn_q && (hs_low != COL_MAX))
        hs_low <= hs_low + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_SEARCH;
      good_cnt    <= '0;
      last_fmt    <= 1'b0;
      format      <= 1'b0;
      locked      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      line_start  <= line_evt;
      frame_start <= frame_evt;
      sync_err    <= 1'b0;

      if (timeout) begin
        state    <= ST_SEARCH;
        locked   <= 1'b0;
        good_cnt <= '0;
      end else begin
        case (state)
          ST_SEARCH: begin
            if (frame_evt) begin
              state    <= ST_MEASURE;
              good_cnt <= '0;
            end
          end
          ST_MEASURE: begin
            if (line_err || frame_err) begin
              sync_err <= 1'b1;
              good_cnt <= '0;
            end else if (frame_good) begin
              last_fmt <= meas_fmt;
              if (cnt_next == LOCK_CNT) begin
                state    <= ST_LOCKED;
                locked   <= 1'b1;
                format   <= meas_fmt;
                good_cnt <= '0;
              end else begin
                good_cnt <= cnt_next;
              end
            end
          end
          ST_LOCKED: begin
            if (line_err || frame_err)
              sync_err <= 1'b1;
            if (frame_err) begin
              state    <= ST_MEASURE;
              locked   <= 1'b0;
              good_cnt <= '0;
            end else if (frame_good) begin
              format   <= meas_fmt;
              last_fmt <= meas_fmt;
            end
          end
          default: begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sync_decoder.md
# sync_decoder

Receive-side counterpart to the frame timing generator. It takes the active-low `hsn`/`fsn` sync pair and recovers the column/row raster position and the line-count format (short or long frame). It validates line and frame periods and reports lock. It sits at the input of any consumer that must align to an externally generated frame, such as a capture/overlay path or a self-check monitor on the timing generator output.

## Interface
Parameters:
- `LINE_CLKS`, 459: nominal clocks per line (hsn fall to hsn fall).
- `LINE_TOL`, 2: allowed ± deviation of a measured line period.
- `HSYNC_CLKS`, 29: required hsn low width in clocks, exact.
- `FRAME_LINES0`, 259: lines per frame, format 0.
- `FRAME_LINES1`, 312: lines per frame, format 1.
- `LOCK_FRAMES`, 2: consecutive good frames required to assert lock.

Ports:
- `clk` in 1: sole clock. Sync inputs are already in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `hsn` in 1: horizontal sync, active low.
- `fsn` in 1: frame sync, active low.
- `col` out 10: column position; 0 on the first clock of a line.
- `row` out 9: line position; 0 on the first line of a frame.
- `format` out 1: 0 = FRAME_LINES0 frame, 1 = FRAME_LINES1 frame.
- `locked` out 1: timing validated.
- `line_start` out 1: one-clock pulse at each recovered line start.
- `frame_start` out 1: one-clock pulse at each recovered frame start, coincident with `line_start`.
- `sync_err` out 1: one-clock pulse on any line or frame check failure.

## Operation
- `hsn` and `fsn` are registered once (`hsn_q`, `fsn_q`). An hsn fall is `hsn_q`=1 with current `hsn`=0.
- **Column counter:**
  - An hsn fall loads 0; otherwise the counter increments.
  - It saturates at 1023. Reaching saturation is a line timeout.
- **Line check at each hsn fall:** the finished line length (`col`+1) must lie in LINE_CLKS±LINE_TOL.
- **Hsync width check:** the hsn low run is counted. At the hsn rise it must equal HSYNC_CLKS, otherwise a line error.
- **Row counter:**
  - Increments on `line_start` and saturates at 511.
  - A frame start is a line start where `fsn` is sampled low and `fsn` was high at the previous line start. At a frame start the row counter loads 0.
- **Frame check at each frame start:**
  - Finished frame length (`row`+1) = FRAME_LINES0 gives a good frame with measured format 0.
  - Finished frame length = FRAME_LINES1 gives a good frame with measured format 1.
  - Any other length is a frame error.
- **State machine:**
  - SEARCH: waits for the first frame start, then goes to MEASURE with good-frame count 0. The first frame is not checked.
  - MEASURE:
    - A good frame increments the good-frame count.
    - Any line or frame error clears the count.
    - A good frame with a format different from the previous good frame also clears the count to 1.
    - When the count reaches LOCK_FRAMES, go to LOCKED, set `locked`=1 and load `format`.
  - LOCKED:
    - A line error pulses `sync_err` only.
    - A frame error pulses `sync_err`, clears `locked` and goes to MEASURE with count 0.
    - A good frame updates `format`.
  - Line timeout, in any state: go to SEARCH, clear `locked`, row counter to 0.
- `format` holds its value outside LOCKED.
- `sync_err` fires in every state except SEARCH.
- **Simultaneous line and frame error:** one `sync_err` pulse; the frame-error transition takes precedence.

## Timing
- **Reset values:** `col`=0, `row`=0, `format`=0, `locked`=0, `line_start`=0, `frame_start`=0, `sync_err`=0, state SEARCH, `hsn_q`=`fsn_q`=1.
- **Line start latency:** if `hsn` is first sampled low at edge N, then `line_start`=1 and `col`=0 in the cycle after edge N+1. `row` updates in that same cycle.
- **Error and lock latency:** `sync_err`, `locked` and `format` change in the same cycle as the `line_start` or `frame_start` that completes the check. The hsync width error appears the cycle after the hsn rise is sampled.
- **Reset mid-frame:** all outputs return to reset values immediately (asynchronous). Recovery then starts from SEARCH.

## Structure
- A shared package holds:
  - the state enum (SEARCH, MEASURE, LOCKED);
  - column/row width constants (10, 9);
  - default timing constants, common with the timing generator so both ends agree.
- One sub-module is natural: `sync_edge_detect`, the register plus fall/rise pulse for one sync input, instantiated for `hsn` and `fsn`.

## Test plan
- **Nominal format 0:** generator-conformant stream (459 clk lines, 29 clk hsync, 259 lines, 8 fsn lines) → `locked` rises at the frame start completing the 2nd good frame; `format`=0; `row` wraps 258→0; `col` wraps 458→0.
- **Nominal format 1:** same stream with 312 lines → lock after 2 good frames; `format`=1; `row` reaches 311.
- **Line period fault while LOCKED:** one line of 470 clocks → one `sync_err` pulse; `locked` stays 1. A 461-clock line raises no error.
- **Frame length fault:** one frame of 280 lines → `sync_err`; `locked`=0. Lock returns after 2 further good frames.
- **Hsync loss:** `hsn` held high for 1100 clocks → `col` saturates at 1023; state SEARCH; `locked`=0. Lock is reacquired after the 1st frame start plus 2 good frames.
- **Reset mid-line:** `reset_n` pulsed low at `col`=200 while LOCKED → all outputs 0 in the same cycle. Relock completes as in the format 0 case.
